servo_angle_ramp: RTL

SERVO_ANGLE_RAMP -- requirements
Module: servo_angle_ramp

---
 rtl/servo_angle_ramp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/servo_angle_ramp.sv
// ---------------------------------------------------------------------------
// servo_angle_ramp
//
// Slews a servo angle towards a programmable target by at most STEP degrees
// per update frame. The frame counter free-runs; each frame boundary
// produces a one-cycle frame_tick, and the angle moves only on that tick
// while enable is high. snap jumps straight to the target at any time.
//
// Ports
//   clock          single clock for all state (divided fpga clock)
//   reset          asynchronous, active-low reset
//   desired_angle  requested target angle, saturated to MAX_ANGLE on load
//   load           1-cycle strobe, captures desired_angle as the new target
//   snap           1-cycle strobe, forces angle_out to the current target
//   enable         ramp enable; angle_out holds while low
//   angle_out      ramped angle for the PWM generator
//   frame_tick     1-cycle pulse at each frame boundary
//   at_target      high when angle_out equals the target
//   busy           high while ramping (complement of at_target)
//
// State table (decoded every cycle from registered angle_out and target)
//   state     | meaning
//   IDLE      | angle_out == target, nothing to do
//   RAMP_UP   | angle_out <  target, next enabled tick steps upward
//   RAMP_DOWN | angle_out >  target, next enabled tick steps downward
//
// INIT_ANGLE must not exceed MAX_ANGLE, and MAX_ANGLE must fit in 8 bits so
// angle_out[31:8] stays zero.
// ---------------------------------------------------------------------------
module servo_angle_ramp #(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned STEP         = 1,
    parameter int unsigned MAX_ANGLE    = 180,
    parameter int unsigned INIT_ANGLE   = 90
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] desired_angle,
    input  logic        load,
    input  logic        snap,
    input  logic        enable,
    output logic [31:0] angle_out,
    output logic        frame_tick,
    output logic        at_target,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    localparam logic [31:0] LAST_COUNT = 32'(FRAME_CYCLES - 1);
    localparam logic [31:0] STEP_W     = 32'(STEP);
    localparam logic [31:0] MAX_W      = 32'(MAX_ANGLE);
    localparam logic [31:0] INIT_W     = 32'(INIT_ANGLE);

    logic [31:0] counter;
    logic [31:0] target;
    logic [31:0] angle_next;
    logic [31:0] target_next;
    logic [31:0] gap_up;
    logic [31:0] gap_down;
    state_t      state;

    // ------------------------------------------------------------------
    // Frame counter: free-running, independent of enable.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (counter == LAST_COUNT) begin
            counter <= '0;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    // Gated with reset so the tick stays low while held in reset even for
    // a degenerate one-cycle frame.
    assign frame_tick = reset && (counter == LAST_COUNT);

    // ------------------------------------------------------------------
    // State register process: angle and target.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            angle_out <= INIT_W;
            target    <= INIT_W;
        end else begin
            angle_out <= angle_next;
            target    <= target_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state process: state decode plus the next angle/target.
    // The step always uses the target registered before this edge, so a
    // load coinciding with a tick or snap only takes effect afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        state = IDLE;
        if (angle_out < target) begin
            state = RAMP_UP;
        end else if (angle_out > target) begin
            state = RAMP_DOWN;
        end
    end

    // Distances are only used in the state where they are non-negative.
    assign gap_up   = target - angle_out;
    assign gap_down = angle_out - target;

    always_comb begin
        angle_next = angle_out;
        if (snap) begin
            angle_next = target;
        end else if (frame_tick && enable) begin
            unique case (state)
                RAMP_UP:   angle_next = (gap_up <= STEP_W) ? target : angle_out + STEP_W;
                RAMP_DOWN: angle_next = (gap_down <= STEP_W) ? target : angle_out - STEP_W;
                default:   angle_next = angle_out;
            endcase
        end
    end

    always_comb begin
        target_next = target;
        if (load) begin
            target_next = (desired_angle > MAX_W) ? MAX_W : desired_angle;
        end
    end

    // ------------------------------------------------------------------
    // Output process.
    // ------------------------------------------------------------------
    always_comb begin
        at_target = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:    at_target = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

endmodule
